// File: rtl/imm_gen_stage_pkg.sv
// Shared decode types for the immediate-generation stage.
//   itype_e    : immediate format selector carried with each lane.
//   imm_lane_t : one stored lane of a bundle {lane_en, imm, illegal}; imm is
//                held at the widest legal width and sliced by the consumer.
package cpuDefine;

  localparam int ITYPE_W   = 4;
  localparam int IMM_MAX_W = 64;

  // Encodings 9..15 are unassigned and decode as illegal.
  typedef enum logic [ITYPE_W-1:0] {
    I8   = 4'd0,
    I6U  = 4'd1,
    I12  = 4'd2,
    I14  = 4'd3,
    I16  = 4'd4,
    I20  = 4'd5,
    I20H = 4'd6,
    I21  = 4'd7,
    I26  = 4'd8
  } itype_e;

  typedef struct packed {
    logic                 lane_en;
    logic [IMM_MAX_W-1:0] imm;
    logic                 illegal;
  } imm_lane_t;

endpackage

// File: rtl/imm_gen_stage_ext.sv
// Per-lane combinational immediate extractor.
//   lane_en   : lane carries an instruction; when low imm and illegal are 0.
//   instr     : raw 32-bit instruction.
//   itype     : immediate format (cpuDefine::itype_e encoding).
//   is_unsign : zero-extend select, only meaningful for I12.
//   imm       : immediate extended to WIDTH.
//   illegal   : format unknown or not available at this WIDTH.
module imm_ext
  import cpuDefine::*;
#(
  parameter int WIDTH = 32
) (
  input  logic               lane_en,
  input  logic [31:0]        instr,
  input  logic [ITYPE_W-1:0] itype,
  input  logic               is_unsign,
  output logic [WIDTH-1:0]   imm,
  output logic               illegal
);

  localparam bit WIDE = (WIDTH == 64);

  logic [WIDTH-1:0] imm_s;
  logic             bad_s;
  logic             unused_s;

  // Opcode bits above the immediate fields never contribute.
  assign unused_s = ^instr[31:26];

  // Format decode; signed casts sign-extend each field to WIDTH.
  always_comb begin
    imm_s = {WIDTH{1'b0}};
    bad_s = 1'b0;
    case (itype)
      I8:  imm_s = WIDTH'(instr[14:10]);
      I6U: begin
        if (WIDE) begin
          imm_s = WIDTH'(instr[15:10]);
        end else begin
          bad_s = 1'b1;
        end
      end
      I12: begin
        if (is_unsign) begin
          imm_s = WIDTH'(instr[21:10]);
        end else begin
          imm_s = WIDTH'($signed(instr[21:10]));
        end
      end
      I14: imm_s = WIDTH'($signed({instr[23:10], 2'b00}));
      I16: imm_s = WIDTH'($signed({instr[25:10], 2'b00}));
      I20: imm_s = WIDTH'($signed({instr[24:5], 12'd0}));
      I20H: begin
        if (WIDE) begin
          imm_s = WIDTH'($signed({instr[24:5], 32'd0}));
        end else begin
          bad_s = 1'b1;
        end
      end
      I21: imm_s = WIDTH'($signed({instr[4:0], instr[25:10], 2'b00}));
      I26: imm_s = WIDTH'($signed({instr[9:0], instr[25:10], 2'b00}));
      default: bad_s = 1'b1;
    endcase
  end

  assign imm     = lane_en ? imm_s : {WIDTH{1'b0}};
  assign illegal = lane_en & bad_s;

endmodule

// File: rtl/imm_gen_stage.sv
// Immediate-generation stage: extends immediates for a bundle of LANES
// instructions and passes the bundle through a 2-entry skid buffer with
// exactly one cycle of latency.
//   clk, rst      : clock, synchronous active-high reset.
//   in_valid/ready: input handshake; in_ready is registered (skid empty).
//   in_lane_en, in_instr, in_itype, in_is_unsign : per-lane decode inputs.
//   flush         : drop both buffered bundles at the next edge.
//   out_valid/ready: output handshake.
//   out_lane_en, out_imm, out_illegal : per-lane results, driven by flops.
module imm_gen_stage
  import cpuDefine::*;
#(
  parameter int WIDTH = 32,
  parameter int LANES = 2
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [LANES-1:0]              in_lane_en,
  input  logic [LANES-1:0][31:0]        in_instr,
  input  logic [LANES-1:0][ITYPE_W-1:0] in_itype,
  input  logic [LANES-1:0]              in_is_unsign,
  input  logic                          flush,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [LANES-1:0]              out_lane_en,
  output logic [LANES-1:0][WIDTH-1:0]   out_imm,
  output logic [LANES-1:0]              out_illegal
);

  imm_lane_t [LANES-1:0] in_bundle_s;
  imm_lane_t [LANES-1:0] main_r;
  imm_lane_t [LANES-1:0] skid_r;
  imm_lane_t [LANES-1:0] main_nxt_s;
  imm_lane_t [LANES-1:0] skid_nxt_s;
  logic                  main_vld_r;
  logic                  skid_vld_r;
  logic                  main_vld_nxt_s;
  logic                  skid_vld_nxt_s;
  logic                  in_ready_r;
  logic                  in_fire_s;

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    logic [WIDTH-1:0] ext_imm_s;
    logic             ext_ill_s;

    imm_ext #(.WIDTH(WIDTH)) u_ext (
      .lane_en   (in_lane_en[g]),
      .instr     (in_instr[g]),
      .itype     (in_itype[g]),
      .is_unsign (in_is_unsign[g]),
      .imm       (ext_imm_s),
      .illegal   (ext_ill_s)
    );

    assign in_bundle_s[g].lane_en = in_lane_en[g];
    assign in_bundle_s[g].imm     = IMM_MAX_W'(ext_imm_s);
    assign in_bundle_s[g].illegal = ext_ill_s;

    assign out_lane_en[g] = main_r[g].lane_en;
    assign out_imm[g]     = main_r[g].imm[WIDTH-1:0];
    assign out_illegal[g] = main_r[g].illegal;

    // Upper storage bits stay zero when WIDTH is narrower than the struct.
    if (WIDTH < IMM_MAX_W) begin : g_hi
      logic unused_hi_s;
      assign unused_hi_s = ^main_r[g].imm[IMM_MAX_W-1:WIDTH];
    end
  end

  assign in_fire_s = in_valid & in_ready_r;
  assign in_ready  = in_ready_r;
  assign out_valid = main_vld_r;

  // Skid-buffer next state. The skid entry can only be full while main is
  // full, and in_ready is low then, so an accept never coincides with an
  // unload of the skid entry.
  always_comb begin
    main_nxt_s     = main_r;
    skid_nxt_s     = skid_r;
    main_vld_nxt_s = main_vld_r;
    skid_vld_nxt_s = skid_vld_r;
    if (!main_vld_r || out_ready) begin
      if (skid_vld_r) begin
        main_nxt_s     = skid_r;
        main_vld_nxt_s = 1'b1;
        skid_vld_nxt_s = 1'b0;
      end else if (in_fire_s) begin
        main_nxt_s     = in_bundle_s;
        main_vld_nxt_s = 1'b1;
      end else begin
        main_vld_nxt_s = 1'b0;
      end
    end else begin
      if (in_fire_s) begin
        skid_nxt_s     = in_bundle_s;
        skid_vld_nxt_s = 1'b1;
      end else begin
        skid_vld_nxt_s = skid_vld_r;
      end
    end
  end

  // Storage registers; reset and flush both empty the buffer and clear data.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      main_r     <= '0;
      skid_r     <= '0;
      main_vld_r <= 1'b0;
      skid_vld_r <= 1'b0;
      in_ready_r <= 1'b1;
    end else begin
      main_r     <= main_nxt_s;
      skid_r     <= skid_nxt_s;
      main_vld_r <= main_vld_nxt_s;
      skid_vld_r <= skid_vld_nxt_s;
      in_ready_r <= ~skid_vld_nxt_s;
    end
  end

endmodule

// File: tb/tb_imm_gen_stage.sv
module tb_imm_gen_stage;
  import cpuDefine::*;

  logic                clk = 1'b0;
  logic                rst;
  logic                in_valid;
  logic [1:0]          in_lane_en;
  logic [1:0][31:0]    in_instr;
  logic [1:0][3:0]     in_itype;
  logic [1:0]          in_is_unsign;
  logic                flush;
  logic                out_ready;

  logic                in_ready32, out_valid32;
  logic [1:0]          out_lane_en32, out_illegal32;
  logic [1:0][31:0]    out_imm32;
  logic                in_ready64, out_valid64;
  logic [1:0]          out_lane_en64, out_illegal64;
  logic [1:0][63:0]    out_imm64;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  imm_gen_stage #(.WIDTH(32), .LANES(2)) dut32 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready32),
    .in_lane_en(in_lane_en), .in_instr(in_instr), .in_itype(in_itype),
    .in_is_unsign(in_is_unsign), .flush(flush), .out_valid(out_valid32),
    .out_ready(out_ready), .out_lane_en(out_lane_en32), .out_imm(out_imm32),
    .out_illegal(out_illegal32)
  );

  imm_gen_stage #(.WIDTH(64), .LANES(2)) dut64 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready64),
    .in_lane_en(in_lane_en), .in_instr(in_instr), .in_itype(in_itype),
    .in_is_unsign(in_is_unsign), .flush(flush), .out_valid(out_valid64),
    .out_ready(out_ready), .out_lane_en(out_lane_en64), .out_imm(out_imm64),
    .out_illegal(out_illegal64)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; in_lane_en = 2'b00; in_instr = '0;
    in_itype = '0; in_is_unsign = 2'b00; flush = 1'b0; out_ready = 1'b1;
    step(); step();
    rst = 1'b0;
    checks++; if (out_valid32 !== 1'b0) begin errors++; $display("FAIL reset_out_valid32 got %b exp 0", out_valid32); end
    checks++; if (in_ready32 !== 1'b1) begin errors++; $display("FAIL reset_in_ready32 got %b exp 1", in_ready32); end
    checks++; if (out_imm32 !== 64'd0) begin errors++; $display("FAIL reset_out_imm32 got %h exp 0", out_imm32); end
    checks++; if (out_lane_en32 !== 2'b00) begin errors++; $display("FAIL reset_lane_en32 got %b exp 00", out_lane_en32); end
    checks++; if (out_illegal32 !== 2'b00) begin errors++; $display("FAIL reset_illegal32 got %b exp 00", out_illegal32); end
    checks++; if (out_valid64 !== 1'b0 || in_ready64 !== 1'b1) begin errors++; $display("FAIL reset_hs64 got v%b r%b exp v0 r1", out_valid64, in_ready64); end
    checks++; if (out_imm64 !== 128'd0) begin errors++; $display("FAIL reset_out_imm64 got %h exp 0", out_imm64); end
  endtask

  task automatic test_i12();
    in_valid = 1'b1; out_ready = 1'b1; in_lane_en = 2'b11;
    in_instr[0] = 32'h0020_0000; in_itype[0] = I12; in_is_unsign[0] = 1'b0;
    in_instr[1] = 32'h0020_0000; in_itype[1] = I12; in_is_unsign[1] = 1'b1;
    step();
    in_valid = 1'b0;
    checks++; if (out_valid32 !== 1'b1) begin errors++; $display("FAIL i12_valid got %b exp 1", out_valid32); end
    checks++; if (out_imm32[0] !== 32'hFFFF_F800) begin errors++; $display("FAIL i12_signed32 got %h exp fffff800", out_imm32[0]); end
    checks++; if (out_imm32[1] !== 32'h0000_0800) begin errors++; $display("FAIL i12_unsigned32 got %h exp 00000800", out_imm32[1]); end
    checks++; if (out_imm64[0] !== 64'hFFFF_FFFF_FFFF_F800) begin errors++; $display("FAIL i12_signed64 got %h exp fffffffffffff800", out_imm64[0]); end
    checks++; if (out_lane_en32 !== 2'b11) begin errors++; $display("FAIL i12_lane_en got %b exp 11", out_lane_en32); end
    step();
    checks++; if (out_valid32 !== 1'b0) begin errors++; $display("FAIL i12_drain got %b exp 0", out_valid32); end
  endtask

  task automatic test_formats();
    logic [31:0] v_instr [9] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0080_0000, 32'h0000_0400,
                                 32'h0024_68A0, 32'h0100_0000, 32'h0000_0010, 32'h0000_0200,
                                 32'hFFFF_FFFF};
    logic [3:0]  v_type  [9] = '{4'd0, 4'd1, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8, 4'hF};
    logic [31:0] v_e32   [9] = '{32'h0000_001F, 32'h0, 32'hFFFF_8000, 32'h0000_0004,
                                 32'h1234_5000, 32'h0, 32'hFFC0_0000, 32'hF800_0000, 32'h0};
    logic        v_i32   [9] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    logic [63:0] v_e64   [9] = '{64'h1F, 64'h3F, 64'hFFFF_FFFF_FFFF_8000, 64'h4,
                                 64'h1234_5000, 64'hFFF8_0000_0000_0000,
                                 64'hFFFF_FFFF_FFC0_0000, 64'hFFFF_FFFF_F800_0000, 64'h0};
    logic        v_i64   [9] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    out_ready = 1'b1; in_lane_en = 2'b01; in_is_unsign = 2'b00;
    in_instr[1] = 32'hFFFF_FFFF; in_itype[1] = I20H;
    for (int i = 0; i < 9; i++) begin
      in_valid = 1'b1; in_instr[0] = v_instr[i]; in_itype[0] = v_type[i];
      step();
      checks++; if (out_imm32[0] !== v_e32[i] || out_illegal32[0] !== v_i32[i]) begin
        errors++; $display("FAIL fmt32[%0d] got %h/%b exp %h/%b", i, out_imm32[0], out_illegal32[0], v_e32[i], v_i32[i]);
      end
      checks++; if (out_imm64[0] !== v_e64[i] || out_illegal64[0] !== v_i64[i]) begin
        errors++; $display("FAIL fmt64[%0d] got %h/%b exp %h/%b", i, out_imm64[0], out_illegal64[0], v_e64[i], v_i64[i]);
      end
      checks++; if (out_imm32[1] !== 32'd0 || out_illegal32[1] !== 1'b0 || out_lane_en32 !== 2'b01) begin
        errors++; $display("FAIL fmt_lane_off[%0d] got %h/%b/%b exp 0/0/01", i, out_imm32[1], out_illegal32[1], out_lane_en32);
      end
    end
    in_valid = 1'b0;
    step();
  endtask

  task automatic test_back_to_back();
    out_ready = 1'b1; in_lane_en = 2'b11; in_is_unsign = 2'b01;
    in_itype[0] = I12; in_itype[1] = I16;
    for (int i = 0; i < 8; i++) begin
      in_valid = 1'b1;
      in_instr[0] = (i + 1) << 10;
      in_instr[1] = i << 10;
      step();
      checks++; if (out_valid32 !== 1'b1 || in_ready32 !== 1'b1) begin
        errors++; $display("FAIL b2b_hs[%0d] got v%b r%b exp v1 r1", i, out_valid32, in_ready32);
      end
      checks++; if (out_imm32[0] !== 32'(i + 1) || out_imm32[1] !== 32'(4 * i)) begin
        errors++; $display("FAIL b2b_data[%0d] got %h/%h exp %h/%h", i, out_imm32[0], out_imm32[1], 32'(i + 1), 32'(4 * i));
      end
    end
    in_valid = 1'b0;
    step();
    checks++; if (out_valid32 !== 1'b0) begin errors++; $display("FAIL b2b_end got %b exp 0", out_valid32); end
  endtask

  task automatic test_stall();
    in_lane_en = 2'b01; in_itype[0] = I8; in_is_unsign = 2'b00;
    out_ready = 1'b1; in_valid = 1'b1; in_instr[0] = 32'd1 << 10;
    step();
    checks++; if (out_imm32[0] !== 32'd1 || in_ready32 !== 1'b1) begin errors++; $display("FAIL stall_a got %h r%b exp 1 r1", out_imm32[0], in_ready32); end
    out_ready = 1'b0; in_instr[0] = 32'd2 << 10;
    step();
    checks++; if (out_imm32[0] !== 32'd1 || out_valid32 !== 1'b1) begin errors++; $display("FAIL stall_hold1 got %h v%b exp 1 v1", out_imm32[0], out_valid32); end
    checks++; if (in_ready32 !== 1'b0) begin errors++; $display("FAIL stall_ready_drop got %b exp 0", in_ready32); end
    in_instr[0] = 32'd3 << 10;
    step(); step();
    checks++; if (out_imm32[0] !== 32'd1 || in_ready32 !== 1'b0) begin errors++; $display("FAIL stall_hold3 got %h r%b exp 1 r0", out_imm32[0], in_ready32); end
    out_ready = 1'b1;
    step();
    checks++; if (out_imm32[0] !== 32'd2 || in_ready32 !== 1'b1) begin errors++; $display("FAIL stall_release_b got %h r%b exp 2 r1", out_imm32[0], in_ready32); end
    step();
    in_valid = 1'b0;
    checks++; if (out_imm32[0] !== 32'd3 || out_valid32 !== 1'b1) begin errors++; $display("FAIL stall_c got %h v%b exp 3 v1", out_imm32[0], out_valid32); end
    step();
    checks++; if (out_valid32 !== 1'b0) begin errors++; $display("FAIL stall_end got %b exp 0", out_valid32); end
  endtask

  task automatic test_flush();
    in_lane_en = 2'b01; in_itype[0] = I8;
    out_ready = 1'b1; in_valid = 1'b1; in_instr[0] = 32'd4 << 10;
    step();
    out_ready = 1'b0; in_instr[0] = 32'd5 << 10;
    step();
    checks++; if (in_ready32 !== 1'b0) begin errors++; $display("FAIL flush_skid_full got %b exp 0", in_ready32); end
    flush = 1'b1; out_ready = 1'b1; in_instr[0] = 32'd6 << 10;
    step();
    flush = 1'b0; in_valid = 1'b0;
    checks++; if (out_valid32 !== 1'b0 || in_ready32 !== 1'b1) begin errors++; $display("FAIL flush_hs got v%b r%b exp v0 r1", out_valid32, in_ready32); end
    checks++; if (out_valid64 !== 1'b0 || in_ready64 !== 1'b1) begin errors++; $display("FAIL flush_hs64 got v%b r%b exp v0 r1", out_valid64, in_ready64); end
    step();
    checks++; if (out_valid32 !== 1'b0) begin errors++; $display("FAIL flush_not_stored got %b exp 0", out_valid32); end
  endtask

  task automatic test_reset_mid();
    in_lane_en = 2'b11; in_itype[0] = I8; in_itype[1] = I8;
    out_ready = 1'b1; in_valid = 1'b1; in_instr[0] = 32'd7 << 10; in_instr[1] = 32'd7 << 10;
    step();
    out_ready = 1'b0;
    step();
    rst = 1'b1; in_valid = 1'b0;
    step();
    rst = 1'b0; out_ready = 1'b1;
    checks++; if (out_valid32 !== 1'b0 || in_ready32 !== 1'b1) begin errors++; $display("FAIL rstmid_hs got v%b r%b exp v0 r1", out_valid32, in_ready32); end
    checks++; if (out_imm32 !== 64'd0 || out_lane_en32 !== 2'b00) begin errors++; $display("FAIL rstmid_data got %h/%b exp 0/00", out_imm32, out_lane_en32); end
    step();
    checks++; if (out_valid32 !== 1'b0) begin errors++; $display("FAIL rstmid_no_partial got %b exp 0", out_valid32); end
  endtask

  initial begin
    test_reset();
    test_i12();
    test_formats();
    test_back_to_back();
    test_stall();
    test_flush();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/imm_gen_stage.md
IMM_GEN_STAGE -- requirements
Module: imm_gen_stage

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset: clk and rst.
REQ-002 Parameter WIDTH, default 32: immediate width, legal values 32 and 64.
REQ-003 Parameter LANES, default 2: decode lanes per bundle, legal values 1 to 4.
REQ-004 Ports SHALL be, clock and reset first:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- in_valid  in  1  bundle offered.
- in_ready  out  1  bundle accepted when in_valid is also high.
- in_lane_en  in  LANES  per-lane instruction present.
- in_instr  in  LANES x 32  raw instructions.
- in_itype  in  LANES x Itype  immediate format per lane.
- in_is_unsign  in  LANES  zero-extend select for I12.
- flush  in  1  discard all buffered bundles.
- out_valid  out  1  bundle presented.
- out_ready  in  1  consumer accepts.
- out_lane_en  out  LANES  registered copy of in_lane_en.
- out_imm  out  LANES x WIDTH  extended immediates.
- out_illegal  out  LANES  itype unsupported for this WIDTH.

Function
REQ-005 Lanes SHALL move as one bundle; a transfer occurs on a rising edge where valid and ready are both high.
REQ-006 The storage SHALL be a 2-entry skid buffer (main and skid); in_ready SHALL be a register output, high when the skid entry is empty.
REQ-007 Latency SHALL be exactly 1 cycle: a bundle accepted at edge N is presented on out_* after edge N.
REQ-008 Sustained in_valid and out_ready SHALL give 1 bundle per cycle with no bubbles.
REQ-009 When out_valid is high and out_ready is low, the incoming bundle SHALL go to the skid entry and in_ready SHALL drop after that edge. Out_* SHALL be held stable while out_ready is low.
REQ-010 When the skid entry is full and out_ready is high, the main entry SHALL take the skid content, and in_ready SHALL be high after that edge.
REQ-011 When in_valid is high and out_ready is high with one entry occupied, the output SHALL drain and the buffer SHALL refill in the same cycle, with occupancy unchanged.
REQ-012 flush SHALL clear both entries at the next edge and SHALL take priority over simultaneous accept or drain; out_valid is 0 and in_ready is 1 after that edge.
REQ-013 Immediates SHALL be computed before storage, and lanes with lane_en low SHALL store imm 0 and illegal 0. Immediate rules (sext = sign-extend to WIDTH, zext = zero-extend to WIDTH):
- I8: zext instr[14:10].
- I6U: zext instr[15:10]; WIDTH=64 only.
- I12: zext instr[21:10] if is_unsign, else sext instr[21:10].
- I14: sext {instr[23:10],2'b0}.
- I16: sext {instr[25:10],2'b0}.
- I20: sext {instr[24:5],12'b0}.
- I20H: sext instr[24:5] shifted left by 32; WIDTH=64 only.
- I21: sext {instr[4:0],instr[25:10],2'b0}.
- I26: sext {instr[9:0],instr[25:10],2'b0}.
REQ-014 An unknown itype, or I6U/I20H with WIDTH=32, SHALL give imm 0 and illegal 1 for that lane.

Reset
REQ-015 While rst is high at an edge, both entries SHALL be cleared, and after that edge out_valid=0, in_ready=1, out_imm=0, out_lane_en=0, out_illegal=0.
REQ-016 Reset mid-transfer SHALL drop buffered bundles with no partial output.

Structure
REQ-017 cpuDefine SHALL hold the Itype enum, extended with I6U and I20H, and the ImmLane struct {lane_en, imm, illegal}.
REQ-018 The per-lane combinational extension SHALL be sub-module imm_ext, parameterised by WIDTH and instantiated LANES times.

Verification
REQ-019 WIDTH=32, I12 signed, instr[21:10]=0x800 -> out_imm=0xFFFFF800 one cycle after accept; with is_unsign=1 -> 0x00000800.
REQ-020 WIDTH=64, I20H, instr[24:5]=0x80000 -> 0xFFF8_0000_0000_0000; same itype with WIDTH=32 -> imm 0, illegal 1.
REQ-021 Back-to-back 8 bundles, out_ready held 1 -> 8 outputs on 8 consecutive cycles, in order.
REQ-022 out_ready low for 3 cycles while in_valid is high -> in_ready drops after the second accept, no bundle is lost or duplicated, and order is kept on release.
REQ-023 flush asserted while the skid entry is full and in_valid is high -> out_valid=0 and in_ready=1 next cycle, and the offered bundle is not stored.
REQ-024 I26 with instr[9:0]=0x200 and instr[25:10]=0 -> sext of 0x8000000 = 0xF8000000 (WIDTH=32).
